mips_run_controller: RTL and testbench

//   Synthesizable run controller for the MIPS pipeline core. It sequences the

---
 rtl/mips_run_controller_if.sv | 36 +++
 rtl/mips_run_controller.sv | 158 +++++++++++++++
 tb/tb_mips_run_controller.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_run_controller_if.sv
// mips_run_controller_if
//   Groups the run-controller signals shared between the controller and the
//   environment that drives it.
//   master : drives start/pc_in, observes the run status outputs
//   slave  : the controller itself (samples start/pc_in, drives status)
//   Signals:
//     start        level request to begin a run
//     pc_in        current PC of the MIPS core
//     core_reset   reset driven to the core
//     running      high while the core is running
//     done         sticky halt flag
//     timeout      sticky timeout flag
//     final_pc     PC captured when the run terminated
//     cycle_count  RUN edges of the current run
interface mips_run_controller_if #(
  parameter int PC_W = 32
);
  logic            start;
  logic [PC_W-1:0] pc_in;
  logic            core_reset;
  logic            running;
  logic            done;
  logic            timeout;
  logic [PC_W-1:0] final_pc;
  logic [15:0]     cycle_count;

  modport master (
    output start, pc_in,
    input  core_reset, running, done, timeout, final_pc, cycle_count
  );

  modport slave (
    input  start, pc_in,
    output core_reset, running, done, timeout, final_pc, cycle_count
  );
endinterface

// File: rtl/mips_run_controller.sv
// mips_run_controller
//   Sequences the MIPS core reset, counts RUN cycles, detects a halt (PC
//   unchanged for STALL_LIMIT consecutive edges) or a timeout (MAX_CYCLES RUN
//   edges), captures the final PC and parks the core in reset afterwards.
//   Ports:
//     clk    in  system clock, rising edge
//     reset  in  asynchronous active-high reset, returns to IDLE
//     bus    slave side of mips_run_controller_if (start, pc_in in;
//            core_reset, running, done, timeout, final_pc, cycle_count out)
//   All outputs are registered.
module mips_run_controller #(
  parameter int PC_W        = 32,
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 500,
  parameter int STALL_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_run_controller_if.slave bus
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int STAB_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [STAB_W-1:0] stable_cnt_reg, stable_cnt_next;
  logic [PC_W-1:0]   prev_pc_reg, prev_pc_next;
  logic              first_reg, first_next;
  logic              core_reset_reg, core_reset_next;
  logic              running_reg, running_next;
  logic              done_reg, done_next;
  logic              timeout_reg, timeout_next;
  logic [PC_W-1:0]   final_pc_reg, final_pc_next;
  logic [15:0]       cycle_count_reg, cycle_count_next;

  logic [15:0]       cc_inc;
  logic [STAB_W-1:0] stable_calc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      hold_cnt_reg    <= '0;
      stable_cnt_reg  <= '0;
      prev_pc_reg     <= '0;
      first_reg       <= 1'b0;
      core_reset_reg  <= 1'b1;
      running_reg     <= 1'b0;
      done_reg        <= 1'b0;
      timeout_reg     <= 1'b0;
      final_pc_reg    <= '0;
      cycle_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      hold_cnt_reg    <= hold_cnt_next;
      stable_cnt_reg  <= stable_cnt_next;
      prev_pc_reg     <= prev_pc_next;
      first_reg       <= first_next;
      core_reset_reg  <= core_reset_next;
      running_reg     <= running_next;
      done_reg        <= done_next;
      timeout_reg     <= timeout_next;
      final_pc_reg    <= final_pc_next;
      cycle_count_reg <= cycle_count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    hold_cnt_next    = hold_cnt_reg;
    stable_cnt_next  = stable_cnt_reg;
    prev_pc_next     = prev_pc_reg;
    first_next       = first_reg;
    core_reset_next  = core_reset_reg;
    running_next     = running_reg;
    done_next        = done_reg;
    timeout_next     = timeout_reg;
    final_pc_next    = final_pc_reg;
    cycle_count_next = cycle_count_reg;
    cc_inc           = cycle_count_reg + 16'd1;
    stable_calc      = '0;

    case (state_reg)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        core_reset_next = 1'b1;
        running_next    = 1'b0;
        if (bus.start) begin
          state_next       = S_HOLD;
          hold_cnt_next    = HOLD_W'(RST_CYCLES - 1);
          cycle_count_next = '0;
          done_next        = 1'b0;
          timeout_next     = 1'b0;
        end
      end

      S_HOLD: begin
        core_reset_next = 1'b1;
        if (hold_cnt_reg == '0) begin
          // Releasing the core: clear the halt detector so the first RUN
          // edge has no previous PC to compare against.
          state_next      = S_RUN;
          core_reset_next = 1'b0;
          running_next    = 1'b1;
          stable_cnt_next = '0;
          prev_pc_next    = '0;
          first_next      = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt_reg - 1'b1;
        end
      end

      S_RUN: begin
        cycle_count_next = cc_inc;
        prev_pc_next     = bus.pc_in;
        first_next       = 1'b0;
        if (!first_reg && (bus.pc_in == prev_pc_reg))
          stable_calc = stable_cnt_reg + 1'b1;
        stable_cnt_next = stable_calc;
        // Halt is checked first so it wins when both land on the same edge.
        if (stable_calc == STAB_W'(STALL_LIMIT)) begin
          state_next      = S_DONE;
          done_next       = 1'b1;
          final_pc_next   = bus.pc_in;
          core_reset_next = 1'b1;
          running_next    = 1'b0;
        end else if (cc_inc == 16'(MAX_CYCLES)) begin
          state_next      = S_TIMEOUT;
          timeout_next    = 1'b1;
          final_pc_next   = bus.pc_in;
          core_reset_next = 1'b1;
          running_next    = 1'b0;
        end
      end

      default: begin
        state_next      = S_IDLE;
        core_reset_next = 1'b1;
        running_next    = 1'b0;
      end
    endcase
  end

  assign bus.core_reset  = core_reset_reg;
  assign bus.running     = running_reg;
  assign bus.done        = done_reg;
  assign bus.timeout     = timeout_reg;
  assign bus.final_pc    = final_pc_reg;
  assign bus.cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_mips_run_controller.sv
// tb_mips_run_controller
//   Self-checking bench for mips_run_controller. Instance A uses the default
//   parameters and is checked every edge against a run-history model; instance
//   B (MAX_CYCLES=8, STALL_LIMIT=2) covers the coincident halt/timeout case.
module tb_mips_run_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mips_run_controller_if #(.PC_W(32)) bus_a ();
  mips_run_controller_if #(.PC_W(32)) bus_b ();

  mips_run_controller #(
    .PC_W(32), .RST_CYCLES(2), .MAX_CYCLES(500), .STALL_LIMIT(4)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  mips_run_controller #(
    .PC_W(32), .RST_CYCLES(2), .MAX_CYCLES(8), .STALL_LIMIT(2)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model for instance A ----------------
  localparam int M_RST   = 2;
  localparam int M_MAX   = 500;
  localparam int M_STALL = 4;
  localparam int PH_IDLE   = 0;
  localparam int PH_HOLD   = 1;
  localparam int PH_RUN    = 2;
  localparam int PH_PARKED = 3;

  int          m_phase;
  int          m_hold_seen;
  logic [31:0] m_pcs[$];
  logic        m_done;
  logic        m_timeout;
  logic [31:0] m_final;
  int          m_cc;

  // Number of consecutive repeats at the end of this run's PC history.
  function automatic int trailing_repeats();
    int n = 0;
    for (int i = m_pcs.size() - 1; i > 0; i--) begin
      if (m_pcs[i] == m_pcs[i-1]) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_hold_seen = 0;
    m_pcs.delete();
    m_done = 1'b0;
    m_timeout = 1'b0;
    m_final = '0;
    m_cc = 0;
  endtask

  task automatic model_edge(input logic s, input logic [31:0] pc);
    case (m_phase)
      PH_IDLE, PH_PARKED: begin
        if (s) begin
          m_phase = PH_HOLD;
          m_hold_seen = 0;
          m_cc = 0;
          m_done = 1'b0;
          m_timeout = 1'b0;
        end
      end
      PH_HOLD: begin
        m_hold_seen++;
        if (m_hold_seen == M_RST) begin
          m_phase = PH_RUN;
          m_pcs.delete();
        end
      end
      default: begin
        m_pcs.push_back(pc);
        m_cc = m_pcs.size();
        if (trailing_repeats() == M_STALL) begin
          m_phase = PH_PARKED;
          m_done = 1'b1;
          m_final = pc;
        end else if (m_cc == M_MAX) begin
          m_phase = PH_PARKED;
          m_timeout = 1'b1;
          m_final = pc;
        end
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    logic [63:0] act, exp;
    logic [15:0] cc16;
    cc16 = 16'(m_cc);
    act = 64'({bus_a.core_reset, bus_a.running, bus_a.done, bus_a.timeout,
               bus_a.final_pc, bus_a.cycle_count});
    exp = 64'({(m_phase != PH_RUN), (m_phase == PH_RUN), m_done, m_timeout,
               m_final, cc16});
    chk(tag, act, exp);
  endtask

  task automatic step_a(input logic s, input logic [31:0] pc);
    bus_a.start = s;
    bus_a.pc_in = pc;
    @(posedge clk);
    model_edge(s, pc);
    edge_n++;
    #1;
    check_model($sformatf("model_edge%0d", edge_n));
  endtask

  task automatic step_b(input logic s, input logic [31:0] pc);
    bus_b.start = s;
    bus_b.pc_in = pc;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse between clock edges (called at posedge+1).
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    chk({tag, "_cr"}, 64'(bus_a.core_reset), 64'(1));
    chk({tag, "_run"}, 64'(bus_a.running), 64'(0));
    chk({tag, "_cc"}, 64'(bus_a.cycle_count), 64'(0));
    chk({tag, "_done"}, 64'(bus_a.done), 64'(0));
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic        start;
    logic [31:0] pc;
    logic        core_reset;
    logic        running;
    logic        done;
    logic        timeout;
    logic [15:0] cc;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [31:0] pc, input logic cr,
                              input logic run, input logic d, input logic t,
                              input logic [15:0] cc);
    vec_t v;
    v.start = s; v.pc = pc; v.core_reset = cr; v.running = run;
    v.done = d; v.timeout = t; v.cc = cc;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[12];
    int   k;
    logic [31:0] pc;

    vecs[0]  = mk(1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    vecs[1]  = mk(1'b1, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    vecs[2]  = mk(1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    vecs[3]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    vecs[4]  = mk(1'b0, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
    vecs[5]  = mk(1'b0, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
    vecs[6]  = mk(1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3);
    vecs[7]  = mk(1'b0, 32'h104, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4);
    vecs[8]  = mk(1'b0, 32'h104, 1'b0, 1'b1, 1'b0, 1'b0, 16'd5);
    vecs[9]  = mk(1'b0, 32'h104, 1'b0, 1'b1, 1'b0, 1'b0, 16'd6);
    vecs[10] = mk(1'b0, 32'h104, 1'b1, 1'b0, 1'b1, 1'b0, 16'd7);
    vecs[11] = mk(1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 16'd7);

    bus_a.start = 1'b0; bus_a.pc_in = '0;
    bus_b.start = 1'b0; bus_b.pc_in = '0;

    // Reset state
    #1 reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_state_a", 64'({bus_a.core_reset, bus_a.running, bus_a.done, bus_a.timeout,
                              bus_a.final_pc, bus_a.cycle_count}), 64'({4'b1000, 48'h0}));
    chk("reset_state_b", 64'({bus_b.core_reset, bus_b.running, bus_b.done, bus_b.timeout,
                              bus_b.final_pc, bus_b.cycle_count}), 64'({4'b1000, 48'h0}));
    reset = 1'b0;

    // Table-driven first run: hold timing, start ignored in RUN, halt
    for (int i = 0; i < 12; i++) begin
      step_a(vecs[i].start, vecs[i].pc);
      chk($sformatf("vec%0d", i),
          64'({bus_a.core_reset, bus_a.running, bus_a.done, bus_a.timeout, bus_a.cycle_count}),
          64'({vecs[i].core_reset, vecs[i].running, vecs[i].done, vecs[i].timeout, vecs[i].cc}));
    end
    chk("vec_final_pc", 64'(bus_a.final_pc), 64'h104);

    // Start in DONE clears flags; then PC counts to 0x40 and holds
    step_a(1'b1, 32'h0);
    chk("restart_done", 64'(bus_a.done), 64'(0));
    chk("restart_cc", 64'(bus_a.cycle_count), 64'(0));
    chk("restart_cr", 64'(bus_a.core_reset), 64'(1));
    step_a(1'b0, 32'h0);
    step_a(1'b0, 32'h0);
    for (int i = 0; i <= 16; i++) step_a(1'b0, 32'(4 * i));
    k = 0;
    while (m_phase != PH_PARKED && k < 10) begin
      step_a(1'b0, 32'h40);
      k++;
    end
    chk("halt_done", 64'(bus_a.done), 64'(1));
    chk("halt_timeout", 64'(bus_a.timeout), 64'(0));
    chk("halt_final_pc", 64'(bus_a.final_pc), 64'h40);
    chk("halt_cc", 64'(bus_a.cycle_count), 64'(21));
    chk("halt_running", 64'(bus_a.running), 64'(0));
    chk("halt_cr", 64'(bus_a.core_reset), 64'(1));

    // Timeout: never-stable PC = 4*cycle_count
    step_a(1'b1, 32'h0);
    step_a(1'b0, 32'h0);
    step_a(1'b0, 32'h0);
    k = 0;
    while (m_phase != PH_PARKED && k < 600) begin
      step_a(1'b0, 32'(4 * m_cc));
      k++;
    end
    chk("to_timeout", 64'(bus_a.timeout), 64'(1));
    chk("to_done", 64'(bus_a.done), 64'(0));
    chk("to_cc", 64'(bus_a.cycle_count), 64'(500));
    chk("to_final_pc", 64'(bus_a.final_pc), 64'h7CC);

    // start held high throughout a run
    step_a(1'b1, 32'h0);
    step_a(1'b1, 32'h0);
    step_a(1'b1, 32'h0);
    for (int i = 1; i <= 60; i++) begin
      step_a(1'b1, 32'(32'h1000 + 4 * i));
      chk($sformatf("held_start_cc%0d", i), 64'(bus_a.cycle_count), 64'(i));
      chk($sformatf("held_start_cr%0d", i), 64'(bus_a.core_reset), 64'(0));
    end

    // Asynchronous reset in the middle of RUN
    pulse_reset("midrun_reset");
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, 32'h55);
      chk($sformatf("post_reset_idle%0d", i),
          64'({bus_a.core_reset, bus_a.running}), 64'({1'b1, 1'b0}));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset("rand_reset");
      pc = 32'(4 * $urandom_range(0, 2));
      step_a($urandom_range(0, 3) == 0, pc);
    end

    // Instance B: halt and timeout on the same edge, halt wins
    pulse_reset("b_reset");
    step_b(1'b1, 32'h0);
    step_b(1'b0, 32'h0);
    step_b(1'b0, 32'h0);
    chk("b_running", 64'(bus_b.running), 64'(1));
    for (int i = 1; i <= 5; i++) step_b(1'b0, 32'(16 * i));
    step_b(1'b0, 32'h60);
    step_b(1'b0, 32'h60);
    chk("b_edge7", 64'({bus_b.running, bus_b.done, bus_b.cycle_count}),
        64'({1'b1, 1'b0, 16'd7}));
    step_b(1'b0, 32'h60);
    chk("b_both_done", 64'(bus_b.done), 64'(1));
    chk("b_both_timeout", 64'(bus_b.timeout), 64'(0));
    chk("b_both_cc", 64'(bus_b.cycle_count), 64'(8));
    chk("b_both_final", 64'(bus_b.final_pc), 64'h60);

    // Instance B: restart from DONE, pure timeout
    step_b(1'b1, 32'h0);
    chk("b_restart_done", 64'(bus_b.done), 64'(0));
    chk("b_restart_cc", 64'(bus_b.cycle_count), 64'(0));
    step_b(1'b0, 32'h0);
    step_b(1'b0, 32'h0);
    for (int i = 1; i <= 8; i++) step_b(1'b0, 32'(32'h100 + 4 * i));
    chk("b_to_flags", 64'({bus_b.done, bus_b.timeout, bus_b.core_reset, bus_b.running}),
        64'({1'b0, 1'b1, 1'b1, 1'b0}));
    chk("b_to_cc", 64'(bus_b.cycle_count), 64'(8));
    chk("b_to_final", 64'(bus_b.final_pc), 64'h120);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
